// File: rtl/uart_tx_frame_pkg.sv
// uart_tx_frame_pkg: shared encodings for the uart transmitter family
package uart_tx_frame_pkg;
  localparam logic MODE_IDLE = 1'b0;
  localparam logic MODE_BUSY = 1'b1;
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP, ST_BRK} state_e;
  function automatic logic par_bit(int mode, logic acc);
    return (mode == PAR_ODD) ? ~acc : acc;
  endfunction
endpackage

// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if: push handshake, break request and serial line status
interface uart_tx_frame_if #(
  parameter int DATA_BITS = 8,
  parameter int LW = 3
);
  logic [DATA_BITS-1:0] TXDATA;
  logic TXVALID, TXREADY, BRKREQ, TX, TXBUSY, TXDONE;
  logic [LW-1:0] LEVEL;
  modport master (output TXDATA, TXVALID, BRKREQ, input TXREADY, TX, TXBUSY, TXDONE, LEVEL);
  modport slave (input TXDATA, TXVALID, BRKREQ, output TXREADY, TX, TXBUSY, TXDONE, LEVEL);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous word buffer with occupancy count
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int LW = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign full  = level == LW'(DEPTH);
  assign empty = level == '0;
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign rdata = mem[rp];
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      level <= level + LW'(wr) - LW'(rd);
    end
  always_ff @(posedge CLK)
    if (wr) mem[wp] <= wdata;
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: buffered UART transmitter with parity, stop bits and line break
module uart_tx_frame
  import uart_tx_frame_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = PAR_NONE,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic CLK,
  input  logic RESET,
  input  logic BCLK,
  uart_tx_frame_if.slave bus
);
  localparam int CW = $clog2(DATA_BITS);
  state_e state_q, state_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, rdata;
  logic [CW-1:0] cnt_q, cnt_d;
  logic par_q, par_d, tx_q, tx_d, busy_q, done_q, done_d, pop, full, empty;
  logic [LW-1:0] level;

  uart_tx_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH), .LW(LW)) u_fifo (
    .CLK(CLK), .RESET(RESET), .push(bus.TXVALID), .pop(pop), .wdata(bus.TXDATA),
    .rdata(rdata), .full(full), .empty(empty), .level(level)
  );

  // every line transition is gated by the bit-rate enable
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    if (BCLK)
      case (state_q)
        ST_IDLE:
          if (bus.BRKREQ) begin
            state_d = ST_BRK;
            tx_d    = 1'b0;
          end else if (!empty) begin
            pop     = 1'b1;
            sh_d    = rdata;
            tx_d    = 1'b0;
            state_d = ST_START;
          end
        ST_START: begin
          tx_d    = sh_q[0];
          par_d   = sh_q[0];
          sh_d    = sh_q >> 1;
          cnt_d   = '0;
          state_d = ST_DATA;
        end
        ST_DATA:
          if (cnt_q == CW'(DATA_BITS - 1)) begin
            cnt_d   = '0;
            state_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
            tx_d    = (PARITY != PAR_NONE) ? par_bit(PARITY, par_q) : 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
            tx_d  = sh_q[0];
            par_d = par_q ^ sh_q[0];
            sh_d  = sh_q >> 1;
          end
        ST_PAR: begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
          cnt_d   = '0;
        end
        ST_STOP:
          if (cnt_q == CW'(STOP_BITS - 1)) begin
            done_d = 1'b1;
            if (!empty && !bus.BRKREQ) begin
              pop     = 1'b1;
              sh_d    = rdata;
              tx_d    = 1'b0;
              state_d = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        ST_BRK:
          if (!bus.BRKREQ) begin
            tx_d    = 1'b1;
            state_d = ST_IDLE;
          end
        default: state_d = ST_IDLE;
      endcase
  end

  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= MODE_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= (state_d == ST_IDLE) ? MODE_IDLE : MODE_BUSY;
      done_q  <= done_d;
    end

  assign bus.TX      = tx_q;
  assign bus.TXBUSY  = busy_q;
  assign bus.TXDONE  = done_q;
  assign bus.TXREADY = !full;
  assign bus.LEVEL   = level;
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: frame-decoding scoreboard bench for three transmitter configurations
module tb_uart_tx_frame;
  logic CLK = 1'b0, RESET = 1'b0, BCLK = 1'b0;
  uart_tx_frame_if #(.DATA_BITS(8), .LW(3)) b0();
  uart_tx_frame_if #(.DATA_BITS(7), .LW(3)) b1();
  uart_tx_frame_if #(.DATA_BITS(8), .LW(3)) b2();

  uart_tx_frame #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
    .CLK(CLK), .RESET(RESET), .BCLK(BCLK), .bus(b0));
  uart_tx_frame #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut1 (
    .CLK(CLK), .RESET(RESET), .BCLK(BCLK), .bus(b1));
  uart_tx_frame #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut2 (
    .CLK(CLK), .RESET(RESET), .BCLK(BCLK), .bus(b2));

  initial forever #5 CLK = ~CLK;

  typedef struct {int dut; logic [8:0] data; logic [15:0] frame;} vec_t;
  vec_t tbl[7];
  logic [15:0] q0[$], q1[$], q2[$];
  int checks = 0, failures = 0;
  int cnt = 0;
  bit bclk_en = 0;
  event bedge, tick;
  int st[3], idx[3], gap[3];
  logic [15:0] fr[3];
  bit mon_en[3];
  int nb[3] = '{10, 10, 12};
  int b2b = 0, b2b_skip = 0, need_gap = 0;
  int done0 = 0, done1 = 0, done2 = 0;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, e);
    end
  endtask

  function automatic logic [15:0] mkframe(logic [8:0] v, int db, int par, int sb);
    logic [15:0] f = '1;
    logic p = 1'b0;
    int n = 1 + db + ((par != 0) ? 1 : 0) + sb;
    f[0] = 1'b0;
    for (int i = 0; i < db; i++) begin
      f[1+i] = v[i];
      p ^= v[i];
    end
    if (par != 0) f[1+db] = (par == 2) ? ~p : p;
    return f & 16'((32'd1 << n) - 1);
  endfunction

  task automatic expect_frame(int d, logic [8:0] v);
    case (d)
      0: q0.push_back(mkframe(v, 8, 0, 1));
      1: q1.push_back(mkframe(v, 7, 1, 1));
      default: q2.push_back(mkframe(v, 8, 2, 2));
    endcase
  endtask

  task automatic frame_done(int d);
    logic [15:0] e = '0;
    bit have = 0;
    case (d)
      0: if (q0.size() > 0) begin have = 1; e = q0.pop_front(); end
      1: if (q1.size() > 0) begin have = 1; e = q1.pop_front(); end
      default: if (q2.size() > 0) begin have = 1; e = q2.pop_front(); end
    endcase
    if (!have) begin
      checks++;
      failures++;
      $display("FAIL unexpected_frame dut%0d actual=%0h expected=none", d, fr[d]);
    end else chk($sformatf("frame_dut%0d", d), 32'(fr[d]), 32'(e));
  endtask

  task automatic dec(int d, logic tx);
    if (!mon_en[d]) return;
    if (st[d] == 0) begin
      if (tx === 1'b0) begin
        if (d == 0 && b2b_skip) b2b_skip = 0;
        else if (d == 0 && b2b > 0) begin
          chk("b2b_gap", 32'(gap[0]), 0);
          b2b--;
        end
        if (d == 0 && need_gap) begin
          chk("brk_gap_ge1", 32'(gap[0] >= 1), 1);
          need_gap = 0;
        end
        st[d] = 1; fr[d] = '0; idx[d] = 1;
      end else gap[d]++;
    end else begin
      fr[d][idx[d]] = tx;
      idx[d]++;
      if (idx[d] == nb[d]) begin
        st[d] = 0; gap[d] = 0;
        frame_done(d);
      end
    end
  endtask

  // bit-rate enable every 16 clocks; line sampled mid bit period
  initial forever begin
    @(negedge CLK);
    cnt = (cnt + 1) % 16;
    BCLK = bclk_en && cnt == 0;
    if (b0.TXDONE) done0++;
    if (b1.TXDONE) done1++;
    if (b2.TXDONE) done2++;
    if (BCLK) -> bedge;
    if (cnt == 8) begin
      dec(0, b0.TX); dec(1, b1.TX); dec(2, b2.TX);
      -> tick;
    end
  end

  task automatic push(int d, logic [8:0] v);
    case (d)
      0: begin b0.TXDATA = v[7:0]; b0.TXVALID = 1'b1; end
      1: begin b1.TXDATA = v[6:0]; b1.TXVALID = 1'b1; end
      default: begin b2.TXDATA = v[7:0]; b2.TXVALID = 1'b1; end
    endcase
    @(negedge CLK);
    b0.TXVALID = 1'b0; b1.TXVALID = 1'b0; b2.TXVALID = 1'b0;
  endtask

  task automatic drain(int max_ticks);
    int t = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && t < max_ticks) begin
      @(tick);
      t++;
    end
    chk("drain_pending", 32'(q0.size() + q1.size() + q2.size()), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy, low, t;
    logic [8:0] w[6];
    tbl[0] = '{0, 9'h000, 16'h0200};
    tbl[1] = '{1, 9'h041, 16'h0282};
    tbl[2] = '{2, 9'h0A5, 16'h0F4A};
    tbl[3] = '{0, 9'h0FF, 16'h03FE};
    tbl[4] = '{1, 9'h07F, 16'h03FE};
    tbl[5] = '{2, 9'h001, 16'h0C02};
    tbl[6] = '{0, 9'h055, 16'h02AA};
    b0.TXDATA = '0; b0.TXVALID = 0; b0.BRKREQ = 0;
    b1.TXDATA = '0; b1.TXVALID = 0; b1.BRKREQ = 0;
    b2.TXDATA = '0; b2.TXVALID = 0; b2.BRKREQ = 0;
    for (int i = 0; i < 3; i++) begin st[i] = 0; idx[i] = 0; gap[i] = 0; fr[i] = '0; mon_en[i] = 1; end
    repeat (4) @(negedge CLK);
    chk("reset_tx", 32'(b0.TX), 1);
    RESET = 1'b1;
    @(negedge CLK);
    chk("reset_busy", 32'(b0.TXBUSY), 0);
    chk("reset_done", 32'(b0.TXDONE), 0);
    chk("reset_level", 32'(b0.LEVEL), 0);
    chk("reset_ready", 32'(b0.TXREADY), 1);
    chk("reset_tx2", 32'(b2.TX), 1);

    bclk_en = 1;
    @(bedge);
    push(0, 9'h055);
    expect_frame(0, 9'h055);
    chk("same_edge_no_pop_tx", 32'(b0.TX), 1);
    chk("same_edge_level", 32'(b0.LEVEL), 1);
    busy = 0;
    repeat (14) begin @(tick); busy += b0.TXBUSY; end
    chk("busy_periods", 32'(busy), 10);
    chk("done_once", 32'(done0), 1);
    chk("first_frame_seen", 32'(q0.size()), 0);

    for (int i = 0; i < 7; i++) begin
      push(tbl[i].dut, tbl[i].data);
      case (tbl[i].dut)
        0: q0.push_back(tbl[i].frame);
        1: q1.push_back(tbl[i].frame);
        default: q2.push_back(tbl[i].frame);
      endcase
    end
    drain(150);
    repeat (3) @(tick);
    chk("done_count0", 32'(done0), 4);
    chk("done_count1", 32'(done1), 2);
    chk("done_count2", 32'(done2), 2);

    @(tick);
    bclk_en = 0;
    for (int i = 0; i < 6; i++) w[i] = 9'($urandom_range(0, 255));
    for (int i = 0; i < 5; i++) begin
      push(0, w[i]);
      if (i < 4) expect_frame(0, w[i]);
      if (i == 2) begin
        chk("ready_at3", 32'(b0.TXREADY), 1);
        chk("level_at3", 32'(b0.LEVEL), 3);
      end
      if (i == 3) begin
        chk("ready_full", 32'(b0.TXREADY), 0);
        chk("level_full", 32'(b0.LEVEL), 4);
      end
    end
    chk("level_after_drop", 32'(b0.LEVEL), 4);
    b2b_skip = 1;
    b2b = 4;
    bclk_en = 1;
    repeat (11) @(bedge);
    push(0, w[5]);
    expect_frame(0, w[5]);
    chk("push_pop_level", 32'(b0.LEVEL), 3);
    drain(120);
    chk("b2b_all_checked", 32'(b2b), 0);

    @(tick);
    b0.BRKREQ = 1'b1;
    mon_en[0] = 0;
    low = 0;
    for (int i = 0; i < 20; i++) begin
      @(tick);
      low += (b0.TX === 1'b0) ? 1 : 0;
      if (i == 2) begin
        push(0, 9'h0C3);
        expect_frame(0, 9'h0C3);
      end
    end
    chk("brk_low_periods", 32'(low), 20);
    chk("brk_busy", 32'(b0.TXBUSY), 1);
    chk("brk_held_level", 32'(b0.LEVEL), 1);
    b0.BRKREQ = 1'b0;
    st[0] = 0; gap[0] = 0; need_gap = 1; mon_en[0] = 1;
    drain(40);
    chk("brk_gap_checked", 32'(need_gap), 0);

    @(tick);
    mon_en[0] = 0;
    push(0, 9'h000);
    push(0, 9'h000);
    t = 0;
    while (b0.TX !== 1'b0 && t < 40) begin @(tick); t++; end
    chk("rst_start_seen", 32'(t < 40), 1);
    repeat (4) @(tick);
    busy = done0;
    chk("pre_rst_tx_low", 32'(b0.TX), 0);
    RESET = 1'b0;
    #1;
    chk("rst_tx", 32'(b0.TX), 1);
    chk("rst_busy", 32'(b0.TXBUSY), 0);
    chk("rst_level", 32'(b0.LEVEL), 0);
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    repeat (15) @(tick);
    chk("rst_no_done", 32'(done0), 32'(busy));
    chk("rst_idle_tx", 32'(b0.TX), 1);
    chk("rst_idle_busy", 32'(b0.TXBUSY), 0);
    chk("rst_ready", 32'(b0.TXREADY), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised, buffered UART transmitter for the uart_modules family. It serialises words from a small internal FIFO into frames with configurable data width, parity and stop bits. Bit timing comes from the shared baud generator's one-cycle BCLK enable. It adds a ready/valid push interface, back-to-back framing and line-break generation, and replaces the fixed 8N1 single-word transmitter.

## Interface
- DATA_BITS, 8: data bits per frame, legal 5..9.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: legal 1 or 2.
- FIFO_DEPTH, 4: word buffer depth, power of two, ≥2.
- LW, $clog2(FIFO_DEPTH)+1: width of LEVEL (derived).
- CLK  in  1  system clock; single clock domain.
- RESET  in  1  asynchronous, active-low reset.
- BCLK  in  1  bit-rate enable, one CLK cycle wide.
- TXDATA  in  DATA_BITS  word to queue.
- TXVALID  in  1  push request.
- TXREADY  out  1  FIFO not full.
- BRKREQ  in  1  request line break (TX held low).
- TX  out  1  serial line, idles high.
- TXBUSY  out  1  frame or break in progress.
- TXDONE  out  1  one-cycle pulse at end of each frame.
- LEVEL  out  LW  FIFO occupancy, 0..FIFO_DEPTH.

## Operation
- Push: a word is written when TXVALID && TXREADY at the CLK edge. TXREADY = (LEVEL != FIFO_DEPTH). A push while full is ignored and corrupts nothing.
- FSM states: IDLE, START, DATA, PAR, STOP, BRK. All TX transitions occur only on CLK edges where BCLK=1.
- IDLE: TX=1.
  - With BCLK and BRKREQ: go to BRK with TX=0. BRKREQ has priority over a non-empty FIFO.
  - Else with BCLK and FIFO non-empty: pop the head into the shift register, TX=0, go to START.
- START → DATA on BCLK. Output data[0] and shift right; data goes out LSB first.
- DATA lasts DATA_BITS bit periods (bit counter 0..DATA_BITS-1). After the last bit:
  - go to PAR if PARITY≠0;
  - otherwise go to STOP with TX=1.
- PAR bit value:
  - even parity = XOR of the data bits;
  - odd parity = its inverse.
  - PAR lasts one bit period, then STOP with TX=1.
- STOP lasts STOP_BITS bit periods. On the BCLK that ends the last stop bit:
  - TXDONE=1 for that cycle;
  - if FIFO non-empty and BRKREQ=0: pop and go straight to START with TX=0 (back-to-back, no idle gap);
  - else go to IDLE.
- BRK: TX=0 while BRKREQ=1. On the first BCLK with BRKREQ=0, TX=1 and go to IDLE. A new frame can start on the next BCLK at the earliest. BRKREQ is sampled only in IDLE and at frame end; a frame in progress is never truncated.
- TXBUSY = (state ≠ IDLE). It is registered alongside the state.
- Simultaneous push and pop: LEVEL is unchanged, and the data in both words is preserved.
- Push to an empty FIFO on the same edge as an IDLE BCLK: no pop that cycle. The word is sent on the next BCLK.

## Timing
- Reset values: TX=1, TXBUSY=0, TXDONE=0, LEVEL=0, FSM=IDLE, FIFO pointers 0. TXREADY=1 once RESET is released.
- Reset mid-frame: TX returns to 1 asynchronously. The queued words are discarded. No TXDONE is generated.
- Latency: a word pushed into an empty idle FIFO gets its start bit on the first BCLK strictly after the push edge.
- Frame length in BCLK periods = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS.
- TXDONE goes high exactly one bit period after the last stop bit begins (STOP_BITS=1).
- LEVEL and TXREADY update on the CLK edge following a push or pop.

## Structure
- Shared uart package/include holds:
  - FSM state encodings, extending the existing IDLE/BUSY mode defines;
  - PARITY encoding constants (NONE/EVEN/ODD).
- One sub-module, uart_tx_fifo: synchronous FIFO with parameters WIDTH and DEPTH, ports push/pop/full/empty/level, and the same CLK/RESET.
- The top level holds the FSM, shift register, bit counter and parity accumulator.

## Test plan
- 8N1, push 0x55, BCLK every 16 CLK → TX per bit period 0,1,0,1,0,1,0,1,0,1. TXDONE pulses once at the end of the stop bit. TXBUSY is high for 10 bit periods.
- DATA_BITS=7, PARITY=1, push 0x41 → TX 0,1,0,0,0,0,0,1,0(parity),1.
- PARITY=2, STOP_BITS=2, push 0xA5 → parity bit 1, two stop bits high, frame of 12 bit periods.
- FIFO_DEPTH=4, BCLK held low, push 5 words → TXREADY drops after the 4th, LEVEL=4, 5th push dropped. Enable BCLK → four back-to-back frames with no idle bit between them.
- BRKREQ held for 20 bit periods while idle → TX low throughout. After release, TX stays high for at least one bit period before a queued frame starts.
- Assert RESET in the middle of the 4th data bit → TX=1, TXBUSY=0, LEVEL=0 immediately. No TXDONE pulse.
